// File: rtl/bp_cache_req_arbiter_pkg.sv
// Shared types for the cache miss request arbiter: FSM state encoding and port count.
package bp_common_pkg;

  typedef enum logic [1:0] {
    e_idle = 2'd0,
    e_send = 2'd1,
    e_wait = 2'd2
  } bp_cache_req_arb_state_e;

  localparam int bp_cache_req_arb_ports_gp = 2;

endpackage

// File: rtl/bp_cache_req_arb_slot.sv
// One-entry miss buffer: holds a request, then its later metadata; eligible once both are present.
module bp_cache_req_arb_slot
  import bp_common_pkg::*;
#(
  parameter int req_width_p  = 128,
  parameter int meta_width_p = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [req_width_p-1:0]  req_i,
  input  logic                    req_v_i,
  output logic                    ready_o,
  input  logic [meta_width_p-1:0] meta_i,
  input  logic                    meta_v_i,
  input  logic                    clear_i,
  output logic [req_width_p-1:0]  req_o,
  output logic [meta_width_p-1:0] meta_o,
  output logic                    eligible_o
);

  logic                    r_req_full;
  logic                    r_meta_full;
  logic [req_width_p-1:0]  r_req;
  logic [meta_width_p-1:0] r_meta;
  logic                    w_req_take;
  logic                    w_meta_take;

  // Ready depends only on slot occupancy, so a producer may wait for it before raising valid.
  assign ready_o     = ~r_req_full & ~reset_i;
  assign w_req_take  = req_v_i & ready_o;
  assign w_meta_take = meta_v_i & r_req_full & ~r_meta_full;
  assign eligible_o  = r_req_full & r_meta_full;
  assign req_o       = r_req;
  assign meta_o      = r_meta;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_req_full  <= 1'b0;
      r_meta_full <= 1'b0;
      r_req       <= '0;
      r_meta      <= '0;
    end else if (clear_i) begin
      r_req_full  <= 1'b0;
      r_meta_full <= 1'b0;
    end else begin
      if (w_req_take) begin
        r_req      <= req_i;
        r_req_full <= 1'b1;
      end
      if (w_meta_take) begin
        r_meta      <= meta_i;
        r_meta_full <= 1'b1;
      end
    end
  end

  // Metadata is only meaningful for a held request that has none yet.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!meta_v_i || (r_req_full && !r_meta_full));
    end
  end

endmodule

// File: rtl/bp_cache_req_arbiter.sv
// Round-robin arbiter of I-cache/D-cache miss requests onto one engine channel.
// Optional watchdog enabled by defining BP_CACHE_REQ_ARB_TIMEOUT_EN.
module bp_cache_req_arbiter
  import bp_common_pkg::*;
#(
  parameter int req_width_p  = 128,
  parameter int meta_width_p = 16,
  parameter int timeout_p    = 4096
) (
  input  logic                                            clk_i,
  input  logic                                            reset_i,
  input  logic [bp_cache_req_arb_ports_gp*req_width_p-1:0]  cache_req_i,
  input  logic [bp_cache_req_arb_ports_gp-1:0]              cache_req_v_i,
  output logic [bp_cache_req_arb_ports_gp-1:0]              cache_req_ready_o,
  input  logic [bp_cache_req_arb_ports_gp*meta_width_p-1:0] cache_req_metadata_i,
  input  logic [bp_cache_req_arb_ports_gp-1:0]              cache_req_metadata_v_i,
  output logic [bp_cache_req_arb_ports_gp-1:0]              cache_req_complete_o,
  output logic [req_width_p-1:0]                            req_o,
  output logic [meta_width_p-1:0]                           req_meta_o,
  output logic                                              req_v_o,
  input  logic                                              req_ready_i,
  input  logic                                              req_complete_i,
  output logic                                              timeout_o
);

  localparam int P = bp_cache_req_arb_ports_gp;

  if (timeout_p < 2) begin : g_bad_timeout
    $fatal(1, "timeout_p must be at least 2");
  end

  bp_cache_req_arb_state_e r_state, w_state_n;
  logic                    r_grant, w_grant_n;
  logic                    r_rr, w_rr_n;
  logic [P-1:0]            w_eligible;
  logic [P-1:0]            w_clear;
  logic [P-1:0]            w_complete;
  logic                    w_req_v;
  logic [req_width_p-1:0]  w_slot_req  [P];
  logic [meta_width_p-1:0] w_slot_meta [P];

  for (genvar g = 0; g < P; g++) begin : g_slot
    bp_cache_req_arb_slot #(
      .req_width_p (req_width_p),
      .meta_width_p(meta_width_p)
    ) u_slot (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .req_i     (cache_req_i[g*req_width_p +: req_width_p]),
      .req_v_i   (cache_req_v_i[g]),
      .ready_o   (cache_req_ready_o[g]),
      .meta_i    (cache_req_metadata_i[g*meta_width_p +: meta_width_p]),
      .meta_v_i  (cache_req_metadata_v_i[g]),
      .clear_i   (w_clear[g]),
      .req_o     (w_slot_req[g]),
      .meta_o    (w_slot_meta[g]),
      .eligible_o(w_eligible[g])
    );
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= e_idle;
      r_grant <= 1'b0;
      r_rr    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_grant <= w_grant_n;
      r_rr    <= w_rr_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_grant_n  = r_grant;
    w_rr_n     = r_rr;
    w_clear    = '0;
    w_complete = '0;
    w_req_v    = 1'b0;
    case (r_state)
      e_idle: begin
        if (|w_eligible) begin
          w_grant_n = (&w_eligible) ? r_rr : w_eligible[1];
          w_rr_n    = ~w_grant_n;
          w_state_n = e_send;
        end
      end
      e_send: begin
        w_req_v = 1'b1;
        if (req_ready_i) w_state_n = e_wait;
      end
      e_wait: begin
        // Completion is routed in the same cycle; the slot frees at the next edge.
        if (req_complete_i) begin
          w_complete[r_grant] = 1'b1;
          w_clear[r_grant]    = 1'b1;
          w_state_n           = e_idle;
        end
      end
      default: w_state_n = e_idle;
    endcase
  end

  assign req_v_o              = w_req_v & ~reset_i;
  assign req_o                = req_v_o ? w_slot_req[r_grant] : '0;
  assign req_meta_o           = req_v_o ? w_slot_meta[r_grant] : '0;
  assign cache_req_complete_o = w_complete & {P{~reset_i}};

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!req_complete_i || r_state == e_wait);
    end
  end

`ifdef BP_CACHE_REQ_ARB_TIMEOUT_EN
  localparam int cnt_w = $clog2(timeout_p + 1);
  logic [cnt_w-1:0] r_tcnt;
  logic             r_timeout;

  // Counts cycles since the current request entered e_send; saturates at the limit.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_tcnt    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == e_idle && w_state_n == e_send) begin
        r_tcnt <= '0;
      end else if (r_state != e_idle && r_tcnt != cnt_w'(timeout_p)) begin
        r_tcnt <= r_tcnt + 1'b1;
      end
      if (r_state != e_idle && r_tcnt == cnt_w'(timeout_p - 1)) r_timeout <= 1'b1;
    end
  end

  assign timeout_o = r_timeout;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: doc/bp_cache_req_arbiter.md
Name: bp_cache_req_arbiter

Overview:
- Sits directly downstream of the core's two cache-miss request channels: port 0 is the I-cache, port 1 is the D-cache.
- Buffers one miss per port, pairing each request with its later-arriving metadata.
- Round-robin arbitrates the complete request+metadata pairs onto a single engine channel, one outstanding at a time.
- Routes the engine's completion pulse back to the owning port.

Parameters:
- req_width_p, 128, width of one cache request packet.
- meta_width_p, 16, metadata width; the narrower port's metadata is zero-extended by the integrator.
- timeout_p, 4096, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- cache_req_i  in  2*req_width_p  per-port request packet
- cache_req_v_i  in  2  per-port request valid
- cache_req_ready_o  out  2  per-port ready (ready-then-valid)
- cache_req_metadata_i  in  2*meta_width_p  per-port metadata
- cache_req_metadata_v_i  in  2  per-port metadata valid
- cache_req_complete_o  out  2  per-port completion pulse
- req_o  out  req_width_p  granted request to engine
- req_meta_o  out  meta_width_p  granted metadata
- req_v_o  out  1  engine request valid
- req_ready_i  in  1  engine ready (valid/ready handshake)
- req_complete_i  in  1  engine completion pulse
- timeout_o  out  1  sticky watchdog flag (optional feature)

Behaviour:
- Reset: all slots empty, state e_idle, rr pointer = port 0. Output values during reset:
  - cache_req_ready_o = 2'b00
  - cache_req_complete_o = 0
  - req_v_o = 0
  - timeout_o = 0
  - req_o and req_meta_o = 0
- Reset mid-operation discards all slots and any in-flight request with no completion pulse. The engine must be reset together with this block.
- Per-port slot (1 entry), fields: req, meta, req_full, meta_full.
  - cache_req_ready_o[i] = ~req_full[i]; it is registered-derived only and never depends on v_i.
  - v_i & ready captures req; req_full is set next cycle.
  - metadata_v_i[i] captures meta only when req_full & ~meta_full. At any other time it is ignored and an assertion fires.
  - A slot is eligible when req_full & meta_full.
- FSM:
  - e_idle: if any slot is eligible, grant = sole eligible slot. If both are eligible, grant = rr pointer. Latch grant, flip rr pointer to ~grant, go to e_send.
  - e_send: req_v_o = 1, with req_o and req_meta_o driven from the granted slot. On req_ready_i, go to e_wait.
  - e_wait: on req_complete_i, cache_req_complete_o[grant] = 1 in the same cycle, the slot is cleared at the next edge, and the FSM returns to e_idle.
- Latency:
  - metadata_v_i in cycle m gives earliest req_v_o in cycle m+2.
  - Completion is combinational, 0 cycles.
  - cache_req_ready_o[i] re-asserts the cycle after its completion pulse.
- Boundary conditions:
  - req_complete_i outside e_wait is ignored and an assertion fires.
  - The other port can fill its slot during e_send or e_wait, and is served next.
  - Back-to-back requests from the same port are impossible, because ready stays low until completion.
  - The engine holding req_ready_i low indefinitely keeps req_v_o high with stable data.

Optional Feature:
- Macro: BP_CACHE_REQ_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to e_send and increments every cycle in e_send or e_wait.
  - When the count reaches timeout_p, timeout_o sets and is cleared only by reset.
  - The FSM is unaffected.
- Undefined: no counter; timeout_o is tied to 0.

Decomposition:
- Shared package bp_common_pkg holds:
  - bp_cache_req_arb_state_e {e_idle, e_send, e_wait}
  - localparam bp_cache_req_arb_ports_gp = 2
- Sub-module bp_cache_req_arb_slot: the one-entry req+meta buffer with its full flags, ready output and clear input. It is instantiated twice.

Test Plan:
- I-cache request A at cycle 0, metadata at cycle 1 -> req_v_o at cycle 3 with req_o=A and its metadata. ready_i at cycle 3, complete_i at cycle 6 -> cache_req_complete_o=2'b01 at cycle 6; cache_req_ready_o[0] high at cycle 7.
- Both ports fill in the same cycle, rr=0 -> port 0 is served first, then port 1 immediately after port 0's completion; the rr pointer ends at 0.
- Engine holds req_ready_i=0 for 20 cycles -> req_v_o stays 1 with stable req_o/req_meta_o, and no completion pulse occurs.
- D-cache request with no metadata for 50 cycles -> never granted; a later I-cache request is granted and completes first.
- reset_i asserted during e_wait -> next cycle ready_o=2'b00, req_v_o=0, no completion pulse; after reset deasserts, ready_o=2'b11.
- With BP_CACHE_REQ_ARB_TIMEOUT_EN and timeout_p=8: request sent and no completion -> timeout_o rises 8 cycles after e_send entry and stays 1 after the eventual completion.
